// File: rtl/bbox_tracker.sv
// bbox_tracker: colour-keyed bounding-box finder over one video frame.
// Accumulates min/max X/Y of key-matching pixels during a frame and
// publishes the box two clocks after frame_end for the overlay stage.
module bbox_tracker #(
  parameter int unsigned X_OFS      = 320,
  parameter int unsigned Y_OFS      = 45,
  parameter int unsigned ACT_W      = 640,
  parameter int unsigned ACT_H      = 480,
  parameter logic [4:0]  R_MIN      = 5'd20,
  parameter logic [5:0]  G_MAX      = 6'd24,
  parameter logic [4:0]  B_MAX      = 5'd12,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] dot,
  input  logic [19:0] y_count_in,
  input  logic        pix_valid,
  input  logic [15:0] pix_rgb,
  input  logic        frame_start,
  input  logic        frame_end,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic        box_valid,
  output logic [19:0] match_count,
  output logic        frame_done
);

  localparam int unsigned CW    = 11;
  localparam int unsigned CNT_W = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    min_x_q, min_x_d, max_x_q, max_x_d;
  logic [CW-1:0]    min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    snap_min_x_q, snap_min_x_d, snap_max_x_q, snap_max_x_d;
  logic [CW-1:0]    snap_min_y_q, snap_min_y_d, snap_max_y_q, snap_max_y_d;
  logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic             pend_q, pend_d;
  logic             acc_en, acc_clr;

  logic [CW-1:0]    x_c, y_c;
  logic             in_win_c, colour_c, hit_c;
  logic             unused_c;

  // Upper counter bits carry no position information in this frame.
  assign unused_c = ^{dot[19:11], y_count_in[19:11]};

  // Active-window coordinates; underflow wraps high and falls outside.
  assign x_c      = dot[10:0] - CW'(X_OFS);
  assign y_c      = y_count_in[10:0] - CW'(Y_OFS);
  assign in_win_c = (x_c < CW'(ACT_W)) && (y_c < CW'(ACT_H));
  assign colour_c = (pix_rgb[15:11] >= R_MIN) && (pix_rgb[10:5] <= G_MAX)
                    && (pix_rgb[4:0] <= B_MAX);
  assign hit_c    = pix_valid && in_win_c && colour_c;

  // Next-state, accumulator update and frame snapshot.
  always_comb begin
    state_d      = state_q;
    min_x_d      = min_x_q;
    max_x_d      = max_x_q;
    min_y_d      = min_y_q;
    max_y_d      = max_y_q;
    cnt_d        = cnt_q;
    snap_min_x_d = snap_min_x_q;
    snap_max_x_d = snap_max_x_q;
    snap_min_y_d = snap_min_y_q;
    snap_max_y_d = snap_max_y_q;
    snap_cnt_d   = snap_cnt_q;
    pend_d       = 1'b0;
    acc_en       = 1'b0;
    acc_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_ACCUM;
          acc_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        acc_en = 1'b1;
        if (frame_end) begin
          state_d = ST_LATCH;
        end else if (frame_start) begin
          acc_clr = 1'b1;
        end
      end
      ST_LATCH: begin
        state_d      = ST_ACCUM;
        acc_clr      = 1'b1;
        pend_d       = 1'b1;
        snap_min_x_d = min_x_q;
        snap_max_x_d = max_x_q;
        snap_min_y_d = min_y_q;
        snap_max_y_d = max_y_q;
        snap_cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_IDLE;
        acc_clr = 1'b1;
      end
    endcase

    if (acc_clr) begin
      min_x_d = {CW{1'b1}};
      max_x_d = '0;
      min_y_d = {CW{1'b1}};
      max_y_d = '0;
      cnt_d   = '0;
    end

    // A hit on a restart cycle lands in the freshly cleared frame.
    if (acc_en && hit_c) begin
      if (x_c < min_x_d) min_x_d = x_c;
      if (x_c > max_x_d) max_x_d = x_c;
      if (y_c < min_y_d) min_y_d = y_c;
      if (y_c > max_y_d) max_y_d = y_c;
      if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // State, accumulator and snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      min_x_q      <= {CW{1'b1}};
      max_x_q      <= '0;
      min_y_q      <= {CW{1'b1}};
      max_y_q      <= '0;
      cnt_q        <= '0;
      snap_min_x_q <= '0;
      snap_max_x_q <= '0;
      snap_min_y_q <= '0;
      snap_max_y_q <= '0;
      snap_cnt_q   <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      cnt_q        <= cnt_d;
      snap_min_x_q <= snap_min_x_d;
      snap_max_x_q <= snap_max_x_d;
      snap_min_y_q <= snap_min_y_d;
      snap_max_y_q <= snap_max_y_d;
      snap_cnt_q   <= snap_cnt_d;
      pend_q       <= pend_d;
    end
  end

  // Published outputs; box coordinates only move on a valid frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      x1          <= '0;
      y1          <= '0;
      x2          <= '0;
      y2          <= '0;
      box_valid   <= 1'b0;
      match_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= pend_q;
      if (pend_q) begin
        match_count <= snap_cnt_q;
        if (snap_cnt_q >= CNT_W'(MIN_PIXELS)) begin
          box_valid <= 1'b1;
          x1        <= snap_min_x_q;
          y1        <= snap_min_y_q;
          x2        <= snap_max_x_q;
          y2        <= snap_max_y_q;
        end else begin
          box_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bbox_tracker.sv
// Testbench for bbox_tracker: directed frames plus random frames checked
// against a hit-list reference model.
module tb_bbox_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] dot;
  logic [19:0] y_count_in;
  logic        pix_valid;
  logic [15:0] pix_rgb;
  logic        frame_start;
  logic        frame_end;
  logic [10:0] x1, y1, x2, y2;
  logic        box_valid;
  logic [19:0] match_count;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: list of hit coordinates in the open frame.
  int hx[$];
  int hy[$];
  bit m_active = 1'b0;
  int e_x1 = 0, e_y1 = 0, e_x2 = 0, e_y2 = 0, e_mc = 0;
  bit e_bv = 1'b0;

  localparam logic [15:0] RED = 16'hF800;

  always #5 clk = ~clk;

  bbox_tracker dut (
    .clk(clk), .reset(reset), .dot(dot), .y_count_in(y_count_in),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .frame_start(frame_start),
    .frame_end(frame_end), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .box_valid(box_valid), .match_count(match_count), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [19:0] d, input logic [19:0] yc,
                                   input logic [15:0] rgb, output int x, output int y);
    x = (int'(d & 20'h7FF) - 320 + 2048) % 2048;
    y = (int'(yc & 20'h7FF) - 45 + 2048) % 2048;
    return (x < 640) && (y < 480) && (rgb[15:11] >= 5'd20) &&
           (rgb[10:5] <= 6'd24) && (rgb[4:0] <= 5'd12);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [19:0] d, input logic [19:0] yc,
                     input logic [15:0] rgb, input bit fe);
    int x, y;
    dot = d; y_count_in = yc; pix_rgb = rgb; pix_valid = 1'b1; frame_end = fe;
    if (m_active && model_hit(d, yc, rgb, x, y)) begin
      hx.push_back(x);
      hy.push_back(y);
    end
    tick();
    pix_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic pix_xy(input int x, input int y, input logic [15:0] rgb, input bit fe);
    pix(20'(x + 320), 20'(y + 45), rgb, fe);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    hx.delete(); hy.delete();
    m_active = 1'b1;
  endtask

  task automatic fe_only();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".x1"}, 32'(x1), 32'(e_x1));
    check({tag, ".y1"}, 32'(y1), 32'(e_y1));
    check({tag, ".x2"}, 32'(x2), 32'(e_x2));
    check({tag, ".y2"}, 32'(y2), 32'(e_y2));
    check({tag, ".box_valid"}, 32'(box_valid), 32'(e_bv));
    check({tag, ".match_count"}, 32'(match_count), 32'(e_mc));
  endtask

  // Called right after the frame_end cycle has been clocked in.
  task automatic finish_frame(input string tag);
    e_mc = (hx.size() > 20'hFFFFF) ? 20'hFFFFF : hx.size();
    if (hx.size() >= 16) begin
      e_bv = 1'b1;
      e_x1 = 2047; e_y1 = 2047; e_x2 = 0; e_y2 = 0;
      foreach (hx[i]) begin
        if (hx[i] < e_x1) e_x1 = hx[i];
        if (hx[i] > e_x2) e_x2 = hx[i];
        if (hy[i] < e_y1) e_y1 = hy[i];
        if (hy[i] > e_y2) e_y2 = hy[i];
      end
    end else begin
      e_bv = 1'b0;
    end
    hx.delete(); hy.delete();
    check({tag, ".fd_e0"}, 32'(frame_done), 0);
    tick();
    check({tag, ".fd_e1"}, 32'(frame_done), 0);
    tick();
    check({tag, ".fd_e2"}, 32'(frame_done), 1);
    check_outputs(tag);
    tick();
    check({tag, ".fd_e3"}, 32'(frame_done), 0);
    check_outputs({tag, ".hold"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dot = '0; y_count_in = '0; pix_valid = 1'b0; pix_rgb = '0;
    frame_start = 1'b0; frame_end = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_outputs("reset");
    check("reset.fd", 32'(frame_done), 0);

    // Three clusters of 20 hits each.
    start_frame();
    for (int i = 0; i < 20; i++) begin
      pix_xy(100, 50, RED, 1'b0);
      pix_xy(300, 200, RED, 1'b0);
      pix_xy(150, 400, RED, 1'b0);
    end
    fe_only();
    finish_frame("f1");

    // Below threshold: box held, count published.
    start_frame();
    for (int i = 0; i < 5; i++) pix_xy(10 + i, 20, RED, 1'b0);
    fe_only();
    finish_frame("f2_low");

    // Outside the active window on each axis.
    start_frame();
    pix(20'd310, 20'd100, RED, 1'b0);
    pix(20'd400, 20'd530, RED, 1'b0);
    pix(20'd319, 20'd44, RED, 1'b0);
    fe_only();
    finish_frame("f3_window");

    // Colour thresholds at their boundaries.
    start_frame();
    for (int i = 0; i < 16; i++) pix_xy(10, 10, {5'd20, 6'd24, 5'd12}, 1'b0);
    pix_xy(500, 300, {5'd19, 6'd0, 5'd0}, 1'b0);
    pix_xy(600, 400, {5'd31, 6'd25, 5'd0}, 1'b0);
    pix_xy(550, 350, {5'd31, 6'd0, 5'd13}, 1'b0);
    fe_only();
    finish_frame("f4_colour");

    // Corner hit together with frame_end.
    start_frame();
    for (int i = 0; i < 16; i++) pix_xy(0, 0, RED, 1'b0);
    pix_xy(639, 479, RED, 1'b1);
    finish_frame("f5_corner");

    // Restart without frame_end discards the partial frame.
    start_frame();
    for (int i = 0; i < 3; i++) pix_xy(5, 5, RED, 1'b0);
    start_frame();
    for (int i = 0; i < 16; i++) pix_xy(200, 100, RED, 1'b0);
    fe_only();
    finish_frame("f6_restart");

    // Random frames with raw counter values including upper bits.
    for (int f = 0; f < 5; f++) begin
      int n;
      start_frame();
      n = $urandom_range(5, 150);
      for (int i = 0; i < n; i++) begin
        logic [15:0] rgb;
        logic [19:0] d, yc;
        d  = {9'($urandom), 11'($urandom_range(250, 1000))};
        yc = {9'($urandom), 11'($urandom_range(30, 560))};
        rgb = 16'($urandom);
        if ($urandom_range(0, 1) == 1)
          rgb = {5'($urandom_range(20, 31)), 6'($urandom_range(0, 24)), 5'($urandom_range(0, 12))};
        pix(d, yc, rgb, (i == n - 1));
      end
      finish_frame($sformatf("rand%0d", f));
    end

    // Reset mid-frame, then frame_end and pixels while idle are ignored.
    start_frame();
    for (int i = 0; i < 20; i++) pix_xy(50, 60, RED, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_active = 1'b0;
    hx.delete(); hy.delete();
    e_x1 = 0; e_y1 = 0; e_x2 = 0; e_y2 = 0; e_bv = 1'b0; e_mc = 0;
    check_outputs("rst_mid");
    fe_only();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_idle.fd%0d", i), 32'(frame_done), 0);
      tick();
    end
    check_outputs("rst_idle");
    for (int i = 0; i < 20; i++) pix_xy(1, 1, RED, 1'b0);
    fe_only();
    tick(); tick();
    check("rst_idle2.fd", 32'(frame_done), 0);
    check_outputs("rst_idle2");
    start_frame();
    for (int i = 0; i < 16; i++) pix_xy(7, 8, RED, 1'b0);
    fe_only();
    finish_frame("rst_resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
